// File: rtl/spgd_meas_sched_if.sv
// Result channel from the SPGD measurement sequencer to the gradient-update logic.
// Handshake: the master holds MEAS_VALID and the J_* words stable until it samples
// MEAS_READY high on a rising edge; the transfer happens on the first edge where both are 1.
// MEAS_READY may be raised before MEAS_VALID and must not depend on MEAS_VALID combinationally.
interface spgd_meas_sched_if #(
    parameter int FP_WIDTH = 64
);
    logic [FP_WIDTH-1:0] J_PLUS;
    logic [FP_WIDTH-1:0] J_MINUS;
    logic [FP_WIDTH-1:0] J_DELTA;
    logic                MEAS_VALID;
    logic                MEAS_READY;

    modport master (
        output J_PLUS,
        output J_MINUS,
        output J_DELTA,
        output MEAS_VALID,
        input  MEAS_READY
    );

    modport slave (
        input  J_PLUS,
        input  J_MINUS,
        input  J_DELTA,
        input  MEAS_VALID,
        output MEAS_READY
    );
endinterface

// File: rtl/spgd_meas_sched.sv
// SPGD measurement sequencer: runs a +/- perturbation measurement pair through the
// calibrated ADC path and presents both words and their difference on a valid/ready channel.
module spgd_meas_sched #(
    parameter int FP_WIDTH       = 64,
    parameter int SETTLE_WIDTH   = 16,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                    ADC_CLK,
    input  logic                    REG_RST,
    input  logic                    START,
    input  logic                    CONTINUOUS,
    input  logic [SETTLE_WIDTH-1:0] SETTLE_CYCLES,
    output logic                    PERT_SIGN,
    output logic                    PERT_VALID,
    output logic                    ADC_EN,
    input  logic                    ADC_DONE,
    input  logic [FP_WIDTH-1:0]     ADC_CAL_OUT,
    output logic                    BUSY,
    output logic                    TIMEOUT_ERR,
    output logic [3:0]              dbg_state,
    spgd_meas_sched_if.master       meas
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        SET_P    = 4'd1,
        SETTLE_P = 4'd2,
        ACQ_P    = 4'd3,
        CAP_P    = 4'd4,
        SET_M    = 4'd5,
        SETTLE_M = 4'd6,
        ACQ_M    = 4'd7,
        CAP_M    = 4'd8,
        PRESENT  = 4'd9,
        ERR      = 4'd10
    } state_t;

    localparam int            TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    state_t                  state_next;
    logic [SETTLE_WIDTH-1:0] settle_cnt;
    logic [TW-1:0]           acq_cnt;
    logic                    settle_done;
    logic                    acq_timeout;
    logic                    in_settle;
    logic                    in_acq;

    // A settle count of 0 or 1 both give a single settle cycle.
    assign in_settle   = (state == SETTLE_P) || (state == SETTLE_M);
    assign in_acq      = (state == ACQ_P) || (state == ACQ_M);
    assign settle_done = (settle_cnt <= SETTLE_WIDTH'(1));
    assign acq_timeout = (acq_cnt == T_LAST);

    always_ff @(posedge ADC_CLK or posedge REG_RST) begin
        if (REG_RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (START) state_next = SET_P;
            SET_P:    state_next = SETTLE_P;
            SETTLE_P: if (settle_done) state_next = ACQ_P;
            ACQ_P: begin
                if (ADC_DONE)         state_next = CAP_P;
                else if (acq_timeout) state_next = ERR;
            end
            CAP_P:    state_next = SET_M;
            SET_M:    state_next = SETTLE_M;
            SETTLE_M: if (settle_done) state_next = ACQ_M;
            ACQ_M: begin
                if (ADC_DONE)         state_next = CAP_M;
                else if (acq_timeout) state_next = ERR;
            end
            CAP_M:    state_next = PRESENT;
            PRESENT:  if (meas.MEAS_READY) state_next = CONTINUOUS ? SET_P : IDLE;
            ERR:      state_next = ERR;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge ADC_CLK or posedge REG_RST) begin
        if (REG_RST) begin
            settle_cnt <= '0;
            acq_cnt    <= '0;
        end else begin
            if ((state == SET_P) || (state == SET_M)) begin
                settle_cnt <= SETTLE_CYCLES;
            end else if (in_settle && !settle_done) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
            acq_cnt <= in_acq ? acq_cnt + 1'b1 : '0;
        end
    end

    // Strobes and enables are registered from the next state so they line up with it.
    always_ff @(posedge ADC_CLK or posedge REG_RST) begin
        if (REG_RST) begin
            PERT_SIGN    <= 1'b0;
            PERT_VALID   <= 1'b0;
            ADC_EN       <= 1'b0;
            meas.J_PLUS  <= '0;
            meas.J_MINUS <= '0;
            meas.J_DELTA <= '0;
        end else begin
            PERT_VALID <= (state_next == SET_P) || (state_next == SET_M);
            if (state_next == SET_P) begin
                PERT_SIGN <= 1'b1;
            end else if (state_next == SET_M) begin
                PERT_SIGN <= 1'b0;
            end
            ADC_EN <= (state_next == ACQ_P) || (state_next == ACQ_M);
            if (state == CAP_P) begin
                meas.J_PLUS <= ADC_CAL_OUT;
            end
            if (state == CAP_M) begin
                meas.J_MINUS <= ADC_CAL_OUT;
                meas.J_DELTA <= meas.J_PLUS - ADC_CAL_OUT;
            end
        end
    end

    assign meas.MEAS_VALID = (state == PRESENT);
    assign BUSY            = (state != IDLE);
    assign TIMEOUT_ERR     = (state == ERR);
    assign dbg_state       = state;

endmodule
